// File: rtl/add_seq_ctrl_pkg.sv
// add_seq_ctrl_pkg: shared state encoding and slice width for the sequenced wide adder
package add_seq_ctrl_pkg;
  localparam int SLICE_W = 32;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/csa_32b_by_rca.sv
// csa_32b_by_rca: 32-bit carry-select adder built from 16-bit ripple-carry blocks
module csa_32b_by_rca (
  output logic [31:0] sum,
  output logic        c_out,
  output logic        ovf,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        c_in
);
  function automatic logic [16:0] rca16(input logic [15:0] x, input logic [15:0] y, input logic ci);
    logic [15:0] s;
    logic c;
    c = ci;
    s = '0;
    for (int i = 0; i < 16; i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    return {c, s};
  endfunction
  logic [16:0] lo, hi0, hi1, hi;
  assign lo  = rca16(a[15:0], b[15:0], c_in);
  assign hi0 = rca16(a[31:16], b[31:16], 1'b0);
  assign hi1 = rca16(a[31:16], b[31:16], 1'b1);
  assign hi  = lo[16] ? hi1 : hi0;
  assign sum = {hi[15:0], lo[15:0]};
  assign c_out = hi[16];
  assign ovf = (a[31] ~^ b[31]) & (sum[31] ^ a[31]);
endmodule

// File: rtl/add_seq_ctrl.sv
// add_seq_ctrl: wide add/subtract sequenced one 32-bit slice per cycle, low word first,
// through a single shared carry-select adder with the carry registered between slices.
module add_seq_ctrl
  import add_seq_ctrl_pkg::*;
#(
  parameter int N_WORDS = 2,
  localparam int W = SLICE_W * N_WORDS
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_sub,
  input  logic         req_cin,
  input  logic [W-1:0] req_a,
  input  logic [W-1:0] req_b,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_sum,
  output logic         res_cout,
  output logic         res_ovf,
  output logic         busy
);
  localparam int CW = N_WORDS > 1 ? $clog2(N_WORDS) : 1;
  state_t state, state_nx;
  logic [W-1:0] a_q, b_q;
  logic [CW-1:0] cnt;
  logic carry, last, accept, c_out, ovf;
  logic [SLICE_W-1:0] a_sl, b_sl, sum;
  assign a_sl = a_q[SLICE_W*int'(cnt) +: SLICE_W];
  assign b_sl = b_q[SLICE_W*int'(cnt) +: SLICE_W];
  assign last = cnt == CW'(N_WORDS - 1);
  assign accept = state == IDLE && req_valid;
  csa_32b_by_rca u_csa (
    .sum  (sum),
    .c_out(c_out),
    .ovf  (ovf),
    .a    (a_sl),
    .b    (b_sl),
    .c_in (carry)
  );
  always_comb begin
    state_nx = state == IDLE ? (req_valid ? RUN : IDLE) :
               state == RUN  ? (last ? DONE : RUN) :
               state == DONE ? (res_ready ? IDLE : DONE) : IDLE;
    req_ready = state == IDLE;
    busy = state != IDLE;
    res_valid = state == DONE;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  // Subtract is a + ~b + 1: the +1 rides in as the slice-0 carry.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_q <= '0;
      b_q <= '0;
      cnt <= '0;
      carry <= 1'b0;
      res_sum <= '0;
      res_cout <= 1'b0;
      res_ovf <= 1'b0;
    end else if (accept) begin
      a_q <= req_a;
      b_q <= req_sub ? ~req_b : req_b;
      carry <= req_sub | req_cin;
      cnt <= '0;
      res_sum <= '0;
    end else if (state == RUN) begin
      res_sum[SLICE_W*int'(cnt) +: SLICE_W] <= sum;
      carry <= c_out;
      if (last) begin
        res_cout <= c_out;
        res_ovf <= ovf;
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_add_seq_ctrl.sv
// tb_add_seq_ctrl: directed checks on N_WORDS=2, plus N_WORDS=1 and N_WORDS=4 builds against a reference model
module tb_add_seq_ctrl;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [2:0] v = '0, rr = '0;
  logic sub_i = 1'b0, cin_i = 1'b0;
  logic [127:0] a_i = '0, b_i = '0;
  logic rq1, rv1, c1, o1, b1;
  logic rq2, rv2, c2, o2, b2;
  logic rq4, rv4, c4, o4, b4;
  logic [31:0] s1;
  logic [63:0] s2;
  logic [127:0] s4;
  int checks = 0, errors = 0;

  always #5 clock = ~clock;

  add_seq_ctrl #(.N_WORDS(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .req_valid(v[0]), .req_ready(rq1), .req_sub(sub_i),
    .req_cin(cin_i), .req_a(a_i[31:0]), .req_b(b_i[31:0]), .res_valid(rv1), .res_ready(rr[0]),
    .res_sum(s1), .res_cout(c1), .res_ovf(o1), .busy(b1));
  add_seq_ctrl #(.N_WORDS(2)) dut2 (
    .clock(clock), .reset_n(reset_n), .req_valid(v[1]), .req_ready(rq2), .req_sub(sub_i),
    .req_cin(cin_i), .req_a(a_i[63:0]), .req_b(b_i[63:0]), .res_valid(rv2), .res_ready(rr[1]),
    .res_sum(s2), .res_cout(c2), .res_ovf(o2), .busy(b2));
  add_seq_ctrl #(.N_WORDS(4)) dut4 (
    .clock(clock), .reset_n(reset_n), .req_valid(v[2]), .req_ready(rq4), .req_sub(sub_i),
    .req_cin(cin_i), .req_a(a_i), .req_b(b_i), .res_valid(rv4), .res_ready(rr[2]),
    .res_sum(s4), .res_cout(c4), .res_ovf(o4), .busy(b4));

  task automatic check(input string tag, input logic [129:0] got, input logic [129:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic rv_of(input int w);
    return w == 0 ? rv1 : w == 1 ? rv2 : rv4;
  endfunction

  function automatic logic [129:0] res_of(input int w);
    return w == 0 ? {c1, o1, 96'b0, s1} : w == 1 ? {c2, o2, 64'b0, s2} : {c4, o4, s4};
  endfunction

  // Issue one request from IDLE; lat counts cycles from the accept cycle up to res_valid.
  task automatic op(input int w, input logic sub, input logic cin, input logic [127:0] a,
                    input logic [127:0] b, output logic [129:0] got, output int lat);
    sub_i = sub; cin_i = cin; a_i = a; b_i = b;
    rr[w] = 1'b0;
    v[w] = 1'b1;
    @(posedge clock); #1;
    v[w] = 1'b0;
    lat = 1;
    while (!rv_of(w) && lat < 40) begin
      @(posedge clock); #1;
      lat++;
    end
    if (!rv_of(w)) check("timeout", 130'(rv_of(w)), 130'd1);
    got = res_of(w);
    rr[w] = 1'b1;
    @(posedge clock); #1;
    rr[w] = 1'b0;
  endtask

  function automatic logic [129:0] model(input logic sub, input logic cin, input logic [127:0] a,
                                         input logic [127:0] b);
    logic [127:0] be;
    logic [128:0] full;
    be = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, be} + 129'(sub | cin);
    return {full[128], (a[127] == be[127]) && (full[127] != a[127]), full[127:0]};
  endfunction

  initial begin
    logic [129:0] got;
    int lat, n;
    #1;
    check("rst_sum", 130'(s2), 130'd0);
    check("rst_flags", 130'({rv2, c2, o2, b2, rq2}), 130'b00001);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    op(1, 1'b0, 1'b0, 128'h00000000_FFFFFFFF, 128'h1, got, lat);
    check("add_carry_slices", got, {2'b00, 128'h00000001_00000000});
    check("latency_n2", 130'(lat), 130'd3);
    op(1, 1'b1, 1'b0, 128'h80000000_00000000, 128'h1, got, lat);
    check("sub_borrow_ovf", got, {2'b11, 128'h7FFFFFFF_FFFFFFFF});
    op(1, 1'b0, 1'b0, 128'h7FFFFFFF_FFFFFFFF, 128'h1, got, lat);
    check("pos_ovf", got, {2'b01, 128'h80000000_00000000});
    op(1, 1'b0, 1'b1, 128'hFFFFFFFF_FFFFFFFF, 128'h0, got, lat);
    check("wrap_cin", got, {2'b10, 128'h0});
    op(1, 1'b1, 1'b1, 128'h5, 128'h5, got, lat);
    check("sub_ignores_cin", got, {2'b10, 128'h0});

    // res_cout is still 1 from the last result, so its reset is observable.
    sub_i = 1'b0; cin_i = 1'b1; a_i = 128'hFFFFFFFF_FFFFFFFF; b_i = 128'h0;
    v[1] = 1'b1;
    @(posedge clock); #1;
    v[1] = 1'b0;
    check("run_busy", 130'(b2), 130'd1);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_out", 130'({rv2, c2, o2, b2, rq2}), 130'b00001);
    check("async_rst_sum", 130'(s2), 130'd0);
    @(negedge clock); @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    op(1, 1'b0, 1'b0, 128'h5, 128'h3, got, lat);
    check("post_rst_no_stale", got, {2'b00, 128'h8});

    sub_i = 1'b0; cin_i = 1'b0; a_i = 128'd10; b_i = 128'd20;
    v[1] = 1'b1;
    @(posedge clock); #1;
    a_i = 128'd1; b_i = 128'd2;
    n = 0;
    while (!rv2 && n < 40) begin
      @(posedge clock); #1;
      n++;
    end
    check("bp_valid", 130'(rv2), 130'd1);
    repeat (5) begin
      @(posedge clock); #1;
      check("bp_sum_stable", 130'(s2), 130'd30);
      check("bp_hold", 130'({rv2, rq2, b2}), 130'b101);
    end
    rr[1] = 1'b1;
    @(posedge clock); #1;
    rr[1] = 1'b0;
    check("bp_release_idle", 130'({rv2, rq2, b2}), 130'b010);
    @(posedge clock); #1;
    v[1] = 1'b0;
    check("bp_second_accept", 130'(b2), 130'd1);
    n = 0;
    while (!rv2 && n < 40) begin
      @(posedge clock); #1;
      n++;
    end
    check("bp_second_sum", {c2, o2, 64'b0, s2}, 130'd3);
    rr[1] = 1'b1;
    @(posedge clock); #1;
    rr[1] = 1'b0;

    op(0, 1'b0, 1'b0, 128'h7FFFFFFF, 128'h1, got, lat);
    check("n1_ovf", got, {2'b01, 96'b0, 32'h80000000});
    check("latency_n1", 130'(lat), 130'd2);
    op(0, 1'b1, 1'b0, 128'h0, 128'h1, got, lat);
    check("n1_borrow", got, {2'b00, 96'b0, 32'hFFFFFFFF});

    op(2, 1'b1, 1'b0, 128'h0, 128'h0, got, lat);
    check("n4_sub_zero", got, {2'b10, 128'h0});
    check("latency_n4", 130'(lat), 130'd5);
    for (int i = 0; i < 1000; i++) begin
      logic [127:0] ra, rb;
      logic rs, rc;
      ra = {$urandom, $urandom, $urandom, $urandom};
      rb = {$urandom, $urandom, $urandom, $urandom};
      if (i % 8 == 0) rb = ~ra;
      rs = 1'($urandom);
      rc = 1'($urandom);
      op(2, rs, rc, ra, rb, got, lat);
      check("n4_random", got, model(rs, rc, ra, rb));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
